// File: rtl/div_unit_pkg.sv
// Shared types and sizing for the multi-cycle integer divider.
// The state codes are fixed so waveform dumps stay readable across revisions.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic               signed_div;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               start;
  logic               annul;
  logic [2*WIDTH-1:0] result;
  logic               ready;

  modport master (
    output signed_div, opdata1, opdata2, start, annul,
    input  result, ready
  );

  modport slave (
    input  signed_div, opdata1, opdata2, start, annul,
    output result, ready
  );

endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle, {remainder, quotient} result.
// Signed division works on magnitudes and fixes the signs once all bits are produced.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  div_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0]   rem, rem_nxt;
  logic [WIDTH-1:0]   quo, quo_nxt;
  logic [WIDTH-1:0]   divisor, divisor_nxt;
  logic               neg_q, neg_q_nxt;
  logic               neg_r, neg_r_nxt;
  logic [2*WIDTH-1:0] result, result_nxt;
  logic               ready, ready_nxt;

  logic [WIDTH:0]     partial;
  logic               no_borrow;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   q_fixed, r_fixed;
  logic [WIDTH-1:0]   mag1, mag2;

  assign bus.result = result;
  assign bus.ready  = ready;

  // quo doubles as the dividend shifter: its MSB feeds the partial remainder
  // while quotient bits enter at the LSB.
  always_comb begin
    partial   = {rem, quo[WIDTH-1]};
    no_borrow = (partial >= {1'b0, divisor});
    diff      = partial[WIDTH-1:0] - divisor;
    q_fixed   = neg_q ? -quo : quo;
    r_fixed   = neg_r ? -rem : rem;
    mag1      = (bus.signed_div && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
    mag2      = (bus.signed_div && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rem_nxt     = rem;
    quo_nxt     = quo;
    divisor_nxt = divisor;
    neg_q_nxt   = neg_q;
    neg_r_nxt   = neg_r;
    result_nxt  = result;
    ready_nxt   = ready;

    case (state)
      DIV_FREE: begin
        ready_nxt  = 1'b0;
        result_nxt = '0;
        if (bus.start && !bus.annul) begin
          if (bus.opdata2 == '0) begin
            state_nxt = DIV_BYZERO;
          end else begin
            state_nxt   = DIV_ON;
            cnt_nxt     = '0;
            rem_nxt     = '0;
            quo_nxt     = mag1;
            divisor_nxt = mag2;
            neg_q_nxt   = bus.signed_div && (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
            neg_r_nxt   = bus.signed_div && bus.opdata1[WIDTH-1];
          end
        end
      end

      // ready follows one cycle later from END so a zero divisor reports two edges after start
      DIV_BYZERO: begin
        ready_nxt  = 1'b0;
        result_nxt = '0;
        state_nxt  = bus.annul ? DIV_FREE : DIV_END;
      end

      DIV_ON: begin
        if (bus.annul) begin
          state_nxt  = DIV_FREE;
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end else if (cnt == CNT_W'(WIDTH)) begin
          state_nxt  = DIV_END;
          ready_nxt  = 1'b1;
          result_nxt = {r_fixed, q_fixed};
        end else begin
          rem_nxt = no_borrow ? diff : partial[WIDTH-1:0];
          quo_nxt = {quo[WIDTH-2:0], no_borrow};
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      DIV_END: begin
        if (bus.start) begin
          ready_nxt = 1'b1;
        end else begin
          state_nxt  = DIV_FREE;
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end
      end

      default: begin
        state_nxt  = DIV_FREE;
        ready_nxt  = 1'b0;
        result_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= DIV_FREE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rem     <= rem_nxt;
      quo     <= quo_nxt;
      divisor <= divisor_nxt;
      neg_q   <= neg_q_nxt;
      neg_r   <= neg_r_nxt;
      result  <= result_nxt;
      ready   <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: fixed vectors, random operands against an
// arithmetic reference, and hand-written abort/reset/handshake sequences.
module tb_div_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Truncating division as the ISA defines it, done in 64-bit arithmetic
  function automatic logic [63:0] model_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    sa = sd ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sd ? longint'($signed(b)) : longint'({32'd0, b});
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Hold start until ready, keep it (with annul pulsed) for hold extra cycles, then release
  task automatic run_div(input string name, input logic sd, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    bus.signed_div = sd;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.opdata1    = $urandom;
    bus.opdata2    = $urandom;
    bus.signed_div = ~sd;
    lat = 0;
    while (!bus.ready && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_result"}, bus.result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.annul = 1'b1;
      @(posedge clk); #1;
      check({name, "_hold_ready"}, 64'(bus.ready), 64'd1);
      check({name, "_hold_result"}, bus.result, exp);
    end
    @(negedge clk);
    bus.annul = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check({name, "_release_ready"}, 64'(bus.ready), 64'd0);
    check({name, "_release_result"}, bus.result, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic        sd, seen;
    int          lat;
    checks   = 0;
    failures = 0;

    vecs.push_back('{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33, 0});
    vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},    33, 0});
    vecs.push_back('{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},           33, 0});
    vecs.push_back('{1'b0, 32'h1234,       32'd0,          64'd0,                           2,  3});
    vecs.push_back('{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000},           33, 0});
    vecs.push_back('{1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'd0},           33, 0});
    vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF, 32'd3},           33, 2});
    vecs.push_back('{1'b0, 32'd5,          32'd9,          {32'd5, 32'd0},                  33, 0});

    rst            = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.start      = 1'b0;
    bus.annul      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(bus.ready), 64'd0);
    check("reset_result", bus.result, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_div($sformatf("vec%0d", i), vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].hold);

    for (int i = 0; i < 24; i++) begin
      sd = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        3:       b = 32'h80000000;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) a = 32'h80000000;
      run_div($sformatf("rand%0d", i), sd, a, b, model_div(sd, a, b), (b == 32'd0) ? 2 : 33, 0);
    end

    // Flush at edge +10 must kill the operation
    @(negedge clk);
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'hFFFFFFFF;
    bus.opdata2    = 32'd3;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.annul = 1'b1;
    @(posedge clk); #1;
    check("annul_ready", 64'(bus.ready), 64'd0);
    @(negedge clk);
    bus.annul = 1'b0;
    bus.start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.ready) seen = 1'b1;
    end
    check("annul_never_ready", 64'(seen), 64'd0);
    run_div("after_annul", 1'b0, 32'hFFFFFFFF, 32'd3, model_div(1'b0, 32'hFFFFFFFF, 32'd3), 33, 0);

    // Reset at edge +20 clears a running division
    @(negedge clk);
    bus.signed_div = 1'b1;
    bus.opdata1    = 32'hFFFFFF9C;
    bus.opdata2    = 32'd7;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("midreset_ready", 64'(bus.ready), 64'd0);
    check("midreset_result", bus.result, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.ready) seen = 1'b1;
    end
    check("midreset_never_ready", 64'(seen), 64'd0);
    run_div("after_reset", 1'b1, 32'hFFFFFF9C, 32'd7, model_div(1'b1, 32'hFFFFFF9C, 32'd7), 33, 0);

    // Dropping start during ON still completes, then END falls straight back to FREE
    @(negedge clk);
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd1000;
    bus.opdata2    = 32'd33;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.ready && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("dropstart_latency", 64'(lat), 64'd33);
    check("dropstart_result", bus.result, {32'd10, 32'd30});
    @(posedge clk); #1;
    check("dropstart_release_ready", 64'(bus.ready), 64'd0);
    check("dropstart_release_result", bus.result, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
